// File: rtl/ifetch_line_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifetch_line_queue: FWFT queue of icache lines with a slot unpacker that  |
// | hands one 32-bit instruction plus its PC to decode per cycle.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ifetch_line_queue #(
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              wr_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              rd_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int SLOTS = LINE_W / 32;
    localparam int SB    = $clog2(SLOTS);
    localparam int SW    = (SB > 0) ? SB : 1;
    localparam int OFS   = SB + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    logic [LINE_W-1:0] line_mem  [DEPTH];
    logic [ADDR_W-1:0] base_mem  [DEPTH];
    logic [SW-1:0]     start_mem [DEPTH];

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     rptr_next;
    logic [CW-1:0]     count;
    logic [SW-1:0]     slot;
    logic [SW-1:0]     slot_in;
    logic [ADDR_W-1:0] base_in;
    logic              last_slot;
    logic              push;
    logic              pop;
    logic              pop_last;
    logic              unused_pc_lsb;

    generate
        if (SB > 0) begin : g_multi_slot
            assign slot_in   = pc_i[SB+1:2];
            assign last_slot = (slot == SW'(SLOTS - 1));
        end else begin : g_single_slot
            assign slot_in   = 1'b0;
            assign last_slot = 1'b1;
        end
    endgenerate

    assign base_in       = {pc_i[ADDR_W-1:OFS], {OFS{1'b0}}};
    assign unused_pc_lsb = ^pc_i[1:0];

    assign full_o    = (count == CW'(DEPTH));
    assign empty_o   = (count == '0);
    assign valid_o   = !empty_o;
    assign push      = wr_i && !full_o;
    assign pop       = rd_i && !empty_o;
    assign pop_last  = pop && last_slot;
    assign rptr_next = rptr + PW'(1);

    assign inst_o = empty_o ? 32'd0 : line_mem[rptr][32*slot +: 32];
    assign pc_o   = empty_o ? '0 : base_mem[rptr] + ADDR_W'({slot, 2'b00});

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            slot  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop_last) begin
                rptr <= rptr_next;
            end
            count <= count + CW'(push) - CW'(pop_last);
            // Leaving the last line while a push lands: the next entry is the one being written now.
            if (pop_last) begin
                if (count == CW'(1)) begin
                    slot <= push ? slot_in : '0;
                end else begin
                    slot <= start_mem[rptr_next];
                end
            end else if (push && empty_o) begin
                slot <= slot_in;
            end else if (pop) begin
                slot <= slot + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && rst_ni && !flush_i) begin
            line_mem[wptr]  <= line_i;
            base_mem[wptr]  <= base_in;
            start_mem[wptr] <= slot_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_line_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifetch_line_queue: scoreboard bench for ifetch_line_queue.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ifetch_line_queue;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         wr;
    logic         rd;
    logic [127:0] line;
    logic [31:0]  pc;
    logic [31:0]  out_inst;
    logic [31:0]  out_pc;
    logic         valid;
    logic         full;
    logic         empty;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_inst [$];
    logic [31:0] exp_pc   [$];

    always #5 clk = ~clk;

    ifetch_line_queue #(.LINE_W(128), .DEPTH(4), .ADDR_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .wr_i   (wr),
        .line_i (line),
        .pc_i   (pc),
        .rd_i   (rd),
        .inst_o (out_inst),
        .pc_o   (out_pc),
        .valid_o(valid),
        .full_o (full),
        .empty_o(empty)
    );

    function automatic logic [127:0] mk_line(input int t);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'hC0DE0000 | 32'(t * 16 + k);
        return l;
    endfunction

    // Expected words of a line from its start slot to the end.
    task automatic exp_line(input logic [127:0] l, input logic [31:0] p);
        for (int k = int'(p[3:2]); k < 4; k++) begin
            exp_inst.push_back(l[32*k +: 32]);
            exp_pc.push_back({p[31:4], 4'b0000} + 32'(4 * k));
        end
    endtask

    task automatic test_reset();
        total++;
        if ({full, empty, valid, out_inst, out_pc} !== {1'b0, 1'b1, 1'b0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_init: got full=%b empty=%b valid=%b inst=%h pc=%h want 0 1 0 0 0",
                     full, empty, valid, out_inst, out_pc);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wr = 1; line = mk_line(i); pc = 32'h40 * i;
        end
        @(negedge clk); wr = 0; rst_n = 0;
        @(negedge clk); rst_n = 1;
        total++;
        if ({full, empty, valid, out_inst, out_pc} !== {1'b0, 1'b1, 1'b0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_mid: got full=%b empty=%b valid=%b inst=%h pc=%h want 0 1 0 0 0",
                     full, empty, valid, out_inst, out_pc);
        end
    endtask

    task automatic test_stream();
        int n;
        @(negedge clk);
        wr = 1; rd = 1; pc = 32'h100;
        line = 128'h44444444_33333333_22222222_11111111;
        exp_line(line, pc);
        n = exp_inst.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); wr = 0; rd = 1;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL stream[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL stream_empty: got empty=%b want 1", empty);
        end
    endtask

    task automatic test_midline();
        int n;
        @(negedge clk);
        wr = 1; rd = 0; pc = 32'h208; line = mk_line(7);
        exp_line(line, pc);
        n = exp_inst.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); wr = 0; rd = 1;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL midline[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL midline_empty: got empty=%b after 2 pops want 1", empty);
        end
    endtask

    task automatic test_full();
        int n;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                total++;
                if (full !== 1'b1) begin
                    bad++; $display("FAIL full_after4: got full=%b want 1", full);
                end
            end
            wr = 1; rd = 0; line = mk_line(10 + i); pc = 32'h1000 + 32'(16 * i);
            if (i < 4) exp_line(line, pc);
        end
        @(negedge clk); wr = 0;
        total++;
        if (full !== 1'b1) begin
            bad++; $display("FAIL full_hold: got full=%b want 1", full);
        end
        n = exp_inst.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rd = 1;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL full_drain[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL full_empty: got empty=%b want 1 (5th line must be absent)", empty);
        end
    endtask

    task automatic test_full_pop_push();
        int n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr = 1; rd = 0; line = mk_line(20 + i); pc = 32'h2000 + 32'(16 * i);
            exp_line(line, pc);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rd = 1;
            wr = (i == 3);
            line = mk_line(30); pc = 32'h3000;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL fpp_head[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0; wr = 1;
        total++;
        if ({full, empty} !== 2'b00) begin
            bad++; $display("FAIL fpp_refused: got full=%b empty=%b want 0 0 (count 3)", full, empty);
        end
        exp_line(line, pc);
        @(negedge clk); wr = 0;
        total++;
        if (full !== 1'b1) begin
            bad++; $display("FAIL fpp_accepted: got full=%b want 1 (count 4)", full);
        end
        n = exp_inst.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rd = 1;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL fpp_drain[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL fpp_empty: got empty=%b want 1", empty);
        end
    endtask

    task automatic test_flush();
        int n;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); wr = 1; rd = 0; line = mk_line(40 + i); pc = 32'h4000 + 32'(16 * i);
        end
        @(negedge clk); wr = 1; flush = 1; line = mk_line(50); pc = 32'h4100;
        @(negedge clk); wr = 0; flush = 0;
        total++;
        if ({empty, valid} !== 2'b10) begin
            bad++; $display("FAIL flush_empty: got empty=%b valid=%b want 1 0", empty, valid);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({valid, out_inst} !== {1'b0, 32'd0}) begin
            bad++; $display("FAIL flush_drop: got valid=%b inst=%h want 0 0", valid, out_inst);
        end
        wr = 1; line = mk_line(51); pc = 32'h50C;
        exp_line(line, pc);
        n = exp_inst.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); wr = 0; rd = 1;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL flush_after[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL flush_after_empty: got empty=%b want 1", empty);
        end
    endtask

    // Last slot of the only line pops in the same cycle a mid-line target is pushed.
    task automatic test_back_to_back();
        int n;
        @(negedge clk); wr = 1; rd = 0; line = mk_line(60); pc = 32'h308;
        exp_line(line, pc);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rd = 1;
            wr = (i == 1);
            line = mk_line(61); pc = 32'h404;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL b2b_a[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        exp_line(line, pc);
        n = exp_inst.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); wr = 0; rd = 1;
            total++;
            if ({valid, out_inst, out_pc} !== {1'b1, exp_inst[0], exp_pc[0]}) begin
                bad++;
                $display("FAIL b2b_b[%0d]: got v=%b inst=%h pc=%h want inst=%h pc=%h",
                         i, valid, out_inst, out_pc, exp_inst[0], exp_pc[0]);
            end
            void'(exp_inst.pop_front()); void'(exp_pc.pop_front());
        end
        @(negedge clk); rd = 0;
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL b2b_empty: got empty=%b want 1", empty);
        end
    endtask

    initial begin
        rst_n = 0; flush = 0; wr = 0; rd = 0; line = '0; pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_stream();
        test_midline();
        test_full();
        test_full_pop_push();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
